// File: rtl/mcb_port_if.sv
// MCB user-port signal bundle: command FIFO, write-data FIFO and read-data FIFO ports.
// The master modport is the initiator side; slave is the memory-controller side.
interface mcb_port_if;
  logic        calib_done;
  logic        cmd_en;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_bl;
  logic [29:0] cmd_byte_addr;
  logic        cmd_empty;
  logic        cmd_full;
  logic        wr_en;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;
  logic        wr_full;
  logic        wr_empty;
  logic [6:0]  wr_count;
  logic        wr_underrun;
  logic        wr_error;
  logic        rd_en;
  logic [31:0] rd_data;
  logic        rd_full;
  logic        rd_empty;
  logic [6:0]  rd_count;
  logic        rd_overflow;
  logic        rd_error;

  modport master (
    input  calib_done, cmd_empty, cmd_full, wr_full, wr_empty, wr_count, wr_underrun, wr_error,
           rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error,
    output cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en
  );

  modport slave (
    output calib_done, cmd_empty, cmd_full, wr_full, wr_empty, wr_count, wr_underrun, wr_error,
           rd_data, rd_full, rd_empty, rd_count, rd_overflow, rd_error,
    input  cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, wr_en, wr_mask, wr_data, rd_en
  );
endinterface

// File: rtl/mcb_port_responder.sv
// MCB user-port responder: cmd/wr/rd FIFOs in front of a word-addressed RAM, standing in for
// the MIG core. Commands execute one at a time from a 4-entry command FIFO.
module mcb_port_responder #(
  parameter int unsigned MEM_AW         = 10,
  parameter int unsigned RD_LATENCY     = 8,
  parameter int unsigned CALIB_CYCLES   = 64,
  parameter int unsigned REFRESH_CYCLES = 16
) (
  input logic       clk,
  input logic       rst_n,
  mcb_port_if.slave mcb_io
);
  localparam int unsigned Words = 2 ** MEM_AW;
  localparam int unsigned CntW  = 16;

  typedef enum logic [2:0] {StIdle, StWrite, StReadWait, StRead, StRefresh} state_e;

  typedef struct packed {
    logic [2:0]        instr;
    logic [5:0]        bl;
    logic [MEM_AW-1:0] ptr;
  } cmd_t;

  // Calibration delay
  logic [CntW-1:0] calib_cnt_q;
  logic            calib_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calib_cnt_q <= '0;
      calib_q     <= 1'b0;
    end else if (!calib_q) begin
      calib_cnt_q <= calib_cnt_q + 1'b1;
      if (calib_cnt_q == CntW'(CALIB_CYCLES - 1)) calib_q <= 1'b1;
    end
  end

  // Command FIFO
  cmd_t       cmd_mem [4];
  cmd_t       cmd_head;
  logic [1:0] cmd_wptr_q, cmd_rptr_q;
  logic [2:0] cmd_cnt_q;
  logic       cmd_push, cmd_pop;

  assign cmd_push = calib_q & mcb_io.cmd_en & (cmd_cnt_q != 3'd4);
  assign cmd_head = cmd_mem[cmd_rptr_q];

  always_ff @(posedge clk) begin
    if (cmd_push) begin
      cmd_mem[cmd_wptr_q] <= {mcb_io.cmd_instr, mcb_io.cmd_bl,
                              mcb_io.cmd_byte_addr[MEM_AW+1:2]};
    end
  end

  // Write-data FIFO: {mask, data}
  logic [35:0] wr_mem [64];
  logic [35:0] wr_head;
  logic [5:0]  wr_wptr_q, wr_rptr_q;
  logic [6:0]  wr_cnt_q;
  logic        wr_push, wr_pop, wr_full;

  assign wr_full = (wr_cnt_q == 7'd64);
  assign wr_push = calib_q & mcb_io.wr_en & ~wr_full;
  assign wr_head = wr_mem[wr_rptr_q];

  always_ff @(posedge clk) begin
    if (wr_push) wr_mem[wr_wptr_q] <= {mcb_io.wr_mask, mcb_io.wr_data};
  end

  // Read-data FIFO and backing RAM
  logic [31:0]       rd_mem [64];
  logic [31:0]       ram [Words];
  logic [5:0]        rd_wptr_q, rd_rptr_q;
  logic [6:0]        rd_cnt_q;
  logic              rd_push, rd_pop, rd_full, rd_empty;
  logic              ram_we;
  logic [MEM_AW-1:0] ptr_q, ptr_d;

  assign rd_full  = (rd_cnt_q == 7'd64);
  assign rd_empty = (rd_cnt_q == 7'd0);
  assign rd_pop   = mcb_io.rd_en & ~rd_empty;

  always_ff @(posedge clk) begin
    if (rd_push) rd_mem[rd_wptr_q] <= ram[ptr_q];
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (!wr_head[32+b]) ram[ptr_q][8*b +: 8] <= wr_head[8*b +: 8];
      end
    end
  end

  // Burst sequencer
  state_e          state_q, state_d;
  logic [6:0]      rem_q, rem_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            underrun, overflow;
  logic            wr_err_q, wr_err_d, rd_err_q, rd_err_d;
  logic            underrun_q, overflow_q;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    cmd_pop  = 1'b0;
    wr_pop   = 1'b0;
    ram_we   = 1'b0;
    rd_push  = 1'b0;
    underrun = 1'b0;
    overflow = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_cnt_q != 3'd0) begin
          cmd_pop = 1'b1;
          ptr_d   = cmd_head.ptr;
          rem_d   = {1'b0, cmd_head.bl} + 7'd1;
          case (cmd_head.instr)
            3'b000, 3'b010: state_d = StWrite;
            3'b001, 3'b011: begin
              if (RD_LATENCY > 1) begin
                state_d = StReadWait;
                cnt_d   = CntW'(RD_LATENCY - 1);
              end else begin
                state_d = StRead;
              end
            end
            3'b100: begin
              state_d = StRefresh;
              cnt_d   = CntW'(REFRESH_CYCLES - 1);
            end
            default: state_d = StIdle;
          endcase
        end
      end
      StWrite: begin
        // A missing word still consumes its slot so the burst keeps its address/length.
        if (wr_cnt_q != 7'd0) begin
          wr_pop = 1'b1;
          ram_we = 1'b1;
        end else begin
          underrun = 1'b1;
        end
        ptr_d = ptr_q + 1'b1;
        rem_d = rem_q - 1'b1;
        if (rem_q == 7'd1) state_d = StIdle;
      end
      StReadWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CntW'(1)) state_d = StRead;
      end
      StRead: begin
        if (!rd_full) rd_push = 1'b1;
        else          overflow = 1'b1;
        ptr_d = ptr_q + 1'b1;
        rem_d = rem_q - 1'b1;
        if (rem_q == 7'd1) state_d = StIdle;
      end
      StRefresh: begin
        if (cnt_q == '0) state_d = StIdle;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign wr_err_d = wr_err_q | underrun | (calib_q & mcb_io.wr_en & wr_full);
  assign rd_err_d = rd_err_q | overflow | (mcb_io.rd_en & rd_empty);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ptr_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      cmd_wptr_q <= '0;
      cmd_rptr_q <= '0;
      cmd_cnt_q  <= '0;
      wr_wptr_q  <= '0;
      wr_rptr_q  <= '0;
      wr_cnt_q   <= '0;
      rd_wptr_q  <= '0;
      rd_rptr_q  <= '0;
      rd_cnt_q   <= '0;
      wr_err_q   <= 1'b0;
      rd_err_q   <= 1'b0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      cnt_q      <= cnt_d;
      cmd_wptr_q <= cmd_wptr_q + 2'(cmd_push);
      cmd_rptr_q <= cmd_rptr_q + 2'(cmd_pop);
      cmd_cnt_q  <= cmd_cnt_q + 3'(cmd_push) - 3'(cmd_pop);
      wr_wptr_q  <= wr_wptr_q + 6'(wr_push);
      wr_rptr_q  <= wr_rptr_q + 6'(wr_pop);
      wr_cnt_q   <= wr_cnt_q + 7'(wr_push) - 7'(wr_pop);
      rd_wptr_q  <= rd_wptr_q + 6'(rd_push);
      rd_rptr_q  <= rd_rptr_q + 6'(rd_pop);
      rd_cnt_q   <= rd_cnt_q + 7'(rd_push) - 7'(rd_pop);
      wr_err_q   <= wr_err_d;
      rd_err_q   <= rd_err_d;
      underrun_q <= underrun;
      overflow_q <= overflow;
    end
  end

  logic unused_addr;
  assign unused_addr = ^{mcb_io.cmd_byte_addr[29:MEM_AW+2], mcb_io.cmd_byte_addr[1:0]};

  assign mcb_io.calib_done  = calib_q;
  assign mcb_io.cmd_empty   = (cmd_cnt_q == 3'd0);
  assign mcb_io.cmd_full    = (cmd_cnt_q == 3'd4);
  assign mcb_io.wr_full     = wr_full;
  assign mcb_io.wr_empty    = (wr_cnt_q == 7'd0);
  assign mcb_io.wr_count    = wr_cnt_q;
  assign mcb_io.wr_underrun = underrun_q;
  assign mcb_io.wr_error    = wr_err_q;
  assign mcb_io.rd_data     = rd_empty ? 32'd0 : rd_mem[rd_rptr_q];
  assign mcb_io.rd_full     = rd_full;
  assign mcb_io.rd_empty    = rd_empty;
  assign mcb_io.rd_count    = rd_cnt_q;
  assign mcb_io.rd_overflow = overflow_q;
  assign mcb_io.rd_error    = rd_err_q;
endmodule

// File: tb/tb_mcb_port_responder.sv
// Bench for mcb_port_responder: a memory/FIFO reference model predicts read data into a
// scoreboard queue; a negedge monitor checks every popped word and counts error pulses.
module tb_mcb_port_responder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mcb_port_if bus ();

  mcb_port_responder #(
    .MEM_AW(10), .RD_LATENCY(8), .CALIB_CYCLES(64), .REFRESH_CYCLES(16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .mcb_io(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_unr    = 0;
  int n_ovf    = 0;
  int exp_unr  = 0;
  int exp_ovf  = 0;
  logic [31:0] last_pop;

  logic [31:0] mem_m [1024];
  logic [35:0] wr_q [$];
  logic [31:0] exp_q [$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic push_wr(input logic [31:0] d, input logic [3:0] m);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    bus.wr_mask = m;
    if (bus.calib_done) wr_q.push_back({m, d});
    tick();
    bus.wr_en = 1'b0;
  endtask

  // Drives one command and applies its effect to the model in program order.
  task automatic issue(input logic [2:0] instr, input int bl, input logic [29:0] addr);
    int base;
    int idx;
    logic [35:0] w;
    bus.cmd_en        = 1'b1;
    bus.cmd_instr     = instr;
    bus.cmd_bl        = 6'(bl);
    bus.cmd_byte_addr = addr;
    tick();
    bus.cmd_en = 1'b0;
    base = int'(addr[11:2]);
    for (int i = 0; i <= bl; i++) begin
      idx = (base + i) % 1024;
      if (instr == 3'b000 || instr == 3'b010) begin
        if (wr_q.size() > 0) begin
          w = wr_q.pop_front();
          for (int b = 0; b < 4; b++) if (!w[32+b]) mem_m[idx][8*b +: 8] = w[8*b +: 8];
        end else begin
          exp_unr++;
        end
      end else if (instr == 3'b001 || instr == 3'b011) begin
        if (exp_q.size() < 64) exp_q.push_back(mem_m[idx]);
        else exp_ovf++;
      end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.cmd_empty !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    if (n >= 1000) begin
      n_checks++;
      n_fail++;
      $display("FAIL cmd_wait_timeout: cmd_empty got %0b, required 1", bus.cmd_empty);
    end
    repeat (100) tick();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      bus.rd_en = !bus.rd_empty && ($urandom_range(3) != 0);
      tick();
      n++;
    end
    bus.rd_en = 1'b0;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d words outstanding, required 0", exp_q.size());
    end
    chk("rd_empty_after_drain", 32'(bus.rd_empty), 32'd1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n) begin
      if (bus.wr_underrun) n_unr++;
      if (bus.rd_overflow) n_ovf++;
      if (bus.rd_en && !bus.rd_empty) begin
        n_checks++;
        last_pop = bus.rd_data;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_pop_unexpected: got %0h, required no word", bus.rd_data);
        end else begin
          e = exp_q.pop_front();
          if (bus.rd_data !== e) begin
            n_fail++;
            $display("FAIL rd_data: got %0h, required %0h", bus.rd_data, e);
          end
        end
      end
    end
  end

  initial begin
    int cyc;
    int lat;
    int a;
    int bl;
    rst_n             = 1'b0;
    bus.cmd_en        = 1'b0;
    bus.cmd_instr     = 3'b0;
    bus.cmd_bl        = 6'd0;
    bus.cmd_byte_addr = 30'd0;
    bus.wr_en         = 1'b0;
    bus.wr_mask       = 4'd0;
    bus.wr_data       = 32'd0;
    bus.rd_en         = 1'b0;
    repeat (3) tick();

    chk("reset_flags", 32'({bus.cmd_empty, bus.wr_empty, bus.rd_empty, bus.cmd_full,
                            bus.wr_full, bus.rd_full, bus.calib_done, bus.wr_error,
                            bus.rd_error, bus.wr_underrun, bus.rd_overflow}),
        32'b111_0000_0000);
    chk("reset_counts", 32'({bus.wr_count, bus.rd_count}), 32'd0);
    chk("reset_rd_data", bus.rd_data, 32'd0);

    // Calibration window: commands and data must be ignored
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 200) begin
      if (cyc == 5) begin
        bus.cmd_en = 1'b1;
        bus.wr_en  = 1'b1;
      end else begin
        bus.cmd_en = 1'b0;
        bus.wr_en  = 1'b0;
      end
      tick();
      cyc++;
      if (bus.calib_done) break;
    end
    chk("calib_rise_cycle", 32'(cyc), 32'd64);
    chk("cmd_empty_precalib", 32'(bus.cmd_empty), 32'd1);
    chk("wr_count_precalib", 32'(bus.wr_count), 32'd0);

    // Full 64-word write then read, with latency measurement
    for (int i = 0; i < 64; i++) push_wr(32'(i), 4'b0000);
    chk("wr_count_full", 32'({bus.wr_full, bus.wr_count}), 32'h0C0);
    issue(3'b000, 63, 30'h0);
    issue(3'b001, 63, 30'h0);
    a = 0;
    while (bus.cmd_empty !== 1'b1 && a < 500) begin
      @(negedge clk);
      a++;
    end
    lat = 0;
    while (bus.rd_empty && lat < 50) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("rd_latency", 32'(lat), 32'd8);
    tick();
    drain();
    chk("errors_clean", 32'({bus.wr_error, bus.rd_error}), 32'd0);
    chk("last_word", last_pop, 32'd63);

    // Byte mask
    push_wr(32'h1122_3344, 4'b0000);
    issue(3'b000, 0, 30'h10);
    push_wr(32'hAABB_CCDD, 4'b0101);
    issue(3'b010, 0, 30'h10);
    issue(3'b011, 0, 30'h10);
    wait_idle();
    drain();
    chk("mask_merge", last_pop, 32'hAA22_CC44);

    // Write underrun: only two of four words available
    for (int i = 0; i < 4; i++) push_wr($urandom, 4'b0000);
    issue(3'b000, 3, 30'h100);
    wait_idle();
    n_unr = 0;
    exp_unr = 0;
    push_wr(32'hCAFE_0000, 4'b0000);
    push_wr(32'hCAFE_0001, 4'b0000);
    issue(3'b000, 3, 30'h100);
    wait_idle();
    chk("underrun_pulses", 32'(n_unr), 32'(exp_unr));
    chk("underrun_pulses_abs", 32'(n_unr), 32'd2);
    chk("wr_error_sticky", 32'(bus.wr_error), 32'd1);
    chk("rd_error_before_ovf", 32'(bus.rd_error), 32'd0);
    issue(3'b001, 3, 30'h100);
    wait_idle();
    drain();

    // Read overflow: two full bursts with nobody popping
    n_ovf = 0;
    exp_ovf = 0;
    issue(3'b001, 63, 30'h0);
    issue(3'b001, 63, 30'h0);
    wait_idle();
    chk("rd_full_count", 32'({bus.rd_full, bus.rd_count}), 32'h0C0);
    chk("overflow_pulses", 32'(n_ovf), 32'(exp_ovf));
    chk("overflow_pulses_abs", 32'(n_ovf), 32'd64);
    chk("rd_error_sticky", 32'(bus.rd_error), 32'd1);
    drain();

    // Address wrap across the top of RAM
    for (int i = 0; i < 4; i++) push_wr($urandom, 4'b0000);
    issue(3'b000, 3, 30'hFFC);
    issue(3'b001, 3, 30'hFFC);
    issue(3'b001, 2, 30'h0);
    wait_idle();
    drain();

    // Randomized bursts with refresh and reserved instructions interleaved
    for (int t = 0; t < 8; t++) begin
      a  = 4 * int'($urandom_range(47));
      bl = int'($urandom_range(15));
      for (int i = 0; i <= bl; i++) push_wr($urandom, 4'($urandom));
      issue(3'($urandom_range(1) * 2), bl, 30'(a));
      issue(($urandom_range(1) == 0) ? 3'b100 : 3'b111, 0, 30'h0);
      issue(3'b001 | 3'($urandom_range(1) * 2), bl, 30'(a));
      wait_idle();
      drain();
    end
    chk("wr_empty_end", 32'(bus.wr_empty), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mcb_port_responder.md
Name: mcb_port_responder

Overview:
Synthesizable responder for the MCB user-port protocol, i.e. the memory-controller end of the cmd/wr/rd FIFO interface that our user_wr_ctrl/user_rd_ctrl initiators drive. It accepts write/read commands, absorbs write data, and returns read data from an internal word-addressed RAM, including FIFO flags, counts and error pulses. It stands in for the MIG core in unit benches and in MIG-less emulation builds.

Parameters:
MEM_AW, 10, log2 of RAM depth in 32-bit words (1024 words = 4 KB)
RD_LATENCY, 8, cycles from read-command pop to first word entering the rd FIFO (min 1)
CALIB_CYCLES, 64, cycles after reset release before calib_done rises
REFRESH_CYCLES, 16, busy cycles for a refresh instruction

Ports:
clk  in  1  single clock for all ports
rst_n  in  1  asynchronous active-low reset
calib_done  out  1  high once calibration delay has elapsed
cmd_en  in  1  push command
cmd_instr  in  3  000/010 write, 001/011 read, 100 refresh, others no-op
cmd_bl  in  6  burst length minus 1 (1..64 words)
cmd_byte_addr  in  30  byte address; bits [1:0] ignored
cmd_empty  out  1  command FIFO empty
cmd_full  out  1  command FIFO full (4 entries)
wr_en  in  1  push write word
wr_mask  in  4  per-byte mask, 1 = byte NOT written
wr_data  in  32  write word
wr_full / wr_empty  out  1 each  write FIFO flags (64 deep)
wr_count  out  7  write FIFO occupancy 0..64
wr_underrun  out  1  one-cycle pulse, write burst ran out of data
wr_error  out  1  sticky error
rd_en  in  1  pop read word
rd_data  out  32  head of read FIFO (first-word-fall-through)
rd_full / rd_empty  out  1 each  read FIFO flags (64 deep)
rd_count  out  7  read FIFO occupancy 0..64
rd_overflow  out  1  one-cycle pulse, read word dropped on full FIFO
rd_error  out  1  sticky error

Behaviour:
- Reset (async, rst_n=0): all FIFOs empty; cmd_empty=1, wr_empty=1, rd_empty=1, fulls=0, counts=0, pulses/stickies=0, calib_done=0, rd_data=0, FSM IDLE, calib counter 0. RAM contents not reset. Reset mid-burst aborts the burst and discards all queued commands/data.
- calib_done rises CALIB_CYCLES clocks after rst_n deasserts, stays high. While calib_done=0, cmd_en and wr_en are ignored.
- Cmd FIFO: push on cmd_en & !cmd_full; cmd_en while full silently dropped. Flags registered, valid the cycle after push/pop.
- Wr FIFO: push on wr_en & !wr_full; wr_en while full: word dropped, wr_error set. Push and internal pop in same cycle: count unchanged.
- FSM states IDLE, WRITE, READ, READ_WAIT, REFRESH.
- IDLE: if cmd FIFO non-empty, pop one entry; load word pointer = byte_addr[MEM_AW+1:2], remaining = bl+1. Go to WRITE, READ_WAIT (latency counter = RD_LATENCY-1), REFRESH (counter = REFRESH_CYCLES-1), or stay IDLE for reserved instr.
- WRITE: one word per cycle. If wr FIFO non-empty: pop, write RAM[ptr] byte-wise honoring mask. If empty when a word is due: write nothing for that slot, pulse wr_underrun, set wr_error, still advance. ptr increments modulo 2^MEM_AW; after last word -> IDLE.
- READ_WAIT: count down, then READ. READ: one word per cycle RAM[ptr] pushed into rd FIFO; if rd FIFO full: word dropped, rd_overflow pulse, rd_error set. After last word -> IDLE.
- REFRESH: count down then IDLE.
- Rd FIFO: rd_data shows head whenever !rd_empty; rd_en pops; rd_en while empty ignored and sets rd_error. Push and pop same cycle: count unchanged.
- Address wrap: a burst crossing RAM top continues at word 0.
- Sticky errors clear only on reset.

Test Plan:
- Reset release -> calib_done=0 for 64 cycles then 1; cmd_en/wr_en before that leave cmd_empty=1, wr_count=0.
- Push 64 words 0..63, write cmd bl=63 addr 0, then read cmd bl=63 addr 0 -> rd_empty falls 8 cycles after read pop; popped data 0..63 in order; no error flags.
- Write word 0xAABBCCDD mask 4'b0101 over prior 0x11223344 at addr 0x10, read back -> 0xAA22CC44.
- Write cmd bl=3 with only 2 words queued -> exactly 2 wr_underrun pulses, wr_error=1, words 2-3 unchanged in RAM.
- Two read cmds bl=63 with rd_en=0 -> rd_count=64, rd_full=1, 64 rd_overflow pulses, rd_error=1.
- Write bl=3 at byte addr 0xFFC (word 1023) -> data lands at words 1023,0,1,2; read back confirms wrap.
